// File: rtl/usr_serial_word_receiver.sv
// Serial-to-parallel word receiver for the USR link with a valid/ready output register.
// Optional parity bit after the data bits is enabled by defining USR_RX_PARITY_EN.
module usr_serial_word_receiver #(
    parameter int DATA_WIDTH = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                            Clk_In,
    input  logic                            Reset_In,
    input  logic                            Start_In,
    input  logic                            Msb_First_In,
    input  logic                            Serial_Valid_In,
    input  logic                            Serial_Data_In,
    input  logic                            Word_Ready_In,
    output logic [DATA_WIDTH-1:0]           Word_Data_Out,
    output logic                            Word_Valid_Out,
    output logic                            Parity_Error_Out,
    output logic                            Overrun_Out,
    output logic                            Abort_Out,
    output logic                            Busy_Out,
    output logic [$clog2(DATA_WIDTH+1)-1:0] Bit_Count_Out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

`ifdef USR_RX_PARITY_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  msb_q, msb_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  overrun_q, overrun_d;
    logic                  abort_q, abort_d;

    logic [DATA_WIDTH-1:0] sreg_shift;
    logic                  done;
    logic [DATA_WIDTH-1:0] done_word;
    logic                  done_perr;

    assign sreg_shift = msb_q ? {sreg_q[DATA_WIDTH-2:0], Serial_Data_In}
                              : {Serial_Data_In, sreg_q[DATA_WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        msb_d     = msb_q;
        word_d    = word_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        abort_d   = 1'b0;
        done      = 1'b0;
        done_word = sreg_shift;
        done_perr = 1'b0;

        if (valid_q && Word_Ready_In) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (Start_In) begin
                    state_d = ST_SHIFT;
                    sreg_d  = '0;
                    cnt_d   = '0;
                    msb_d   = Msb_First_In;
                end
            end
            ST_SHIFT: begin
                // A new start wins over a bit arriving in the same cycle.
                if (Start_In) begin
                    abort_d = 1'b1;
                    sreg_d  = '0;
                    cnt_d   = '0;
                    msb_d   = Msb_First_In;
                end else if (Serial_Valid_In) begin
                    sreg_d = sreg_shift;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef USR_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done    = 1'b1;
`endif
                    end
                end
            end
`ifdef USR_RX_PARITY_EN
            ST_PARITY: begin
                if (Start_In) begin
                    state_d = ST_SHIFT;
                    abort_d = 1'b1;
                    sreg_d  = '0;
                    cnt_d   = '0;
                    msb_d   = Msb_First_In;
                end else if (Serial_Valid_In) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    done      = 1'b1;
                    done_word = sreg_q;
                    done_perr = ((^sreg_q) ^ Serial_Data_In) != PARITY_ODD;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // An unconsumed word is never overwritten; a same-edge transfer frees the slot.
        if (done) begin
            if (valid_q && !Word_Ready_In) begin
                overrun_d = 1'b1;
            end else begin
                word_d  = done_word;
                perr_d  = done_perr;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q   <= ST_IDLE;
            sreg_q    <= '0;
            cnt_q     <= '0;
            msb_q     <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            cnt_q     <= cnt_d;
            msb_q     <= msb_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
            abort_q   <= abort_d;
        end
    end

    assign Word_Data_Out    = word_q;
    assign Word_Valid_Out   = valid_q;
    assign Parity_Error_Out = perr_q;
    assign Overrun_Out      = overrun_q;
    assign Abort_Out        = abort_q;
    assign Busy_Out         = (state_q != ST_IDLE);
    assign Bit_Count_Out    = cnt_q;

endmodule

// File: tb/tb_usr_serial_word_receiver.sv
// Scoreboard bench for usr_serial_word_receiver: word-level reference model feeds an
// expected-word queue that a separate monitor drains on every output transfer.
module tb_usr_serial_word_receiver;

    localparam int DW  = 16;
    localparam bit POD = 1'b0;
    localparam int CW  = $clog2(DW + 1);

    logic          Clk_In = 1'b0;
    logic          Reset_In;
    logic          Start_In, Msb_First_In, Serial_Valid_In, Serial_Data_In, Word_Ready_In;
    logic [DW-1:0] Word_Data_Out;
    logic          Word_Valid_Out, Parity_Error_Out, Overrun_Out, Abort_Out, Busy_Out;
    logic [CW-1:0] Bit_Count_Out;

    usr_serial_word_receiver #(.DATA_WIDTH(DW), .PARITY_ODD(POD)) dut (
        .Clk_In          (Clk_In),
        .Reset_In        (Reset_In),
        .Start_In        (Start_In),
        .Msb_First_In    (Msb_First_In),
        .Serial_Valid_In (Serial_Valid_In),
        .Serial_Data_In  (Serial_Data_In),
        .Word_Ready_In   (Word_Ready_In),
        .Word_Data_Out   (Word_Data_Out),
        .Word_Valid_Out  (Word_Valid_Out),
        .Parity_Error_Out(Parity_Error_Out),
        .Overrun_Out     (Overrun_Out),
        .Abort_Out       (Abort_Out),
        .Busy_Out        (Busy_Out),
        .Bit_Count_Out   (Bit_Count_Out)
    );

    always #5 Clk_In = ~Clk_In;

    typedef struct {
        logic [DW-1:0] w;
        logic          pe;
    } exp_t;

    exp_t    sb_q[$];
    int      checks = 0;
    int      errors = 0;

    // Reference model: word position of each received bit, output slot occupancy.
    bit      m_busy, m_full, m_msb, m_inpar;
    int      m_cnt;
    logic [DW-1:0] m_word;
    int      rdy_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_full = 0; m_msb = 0; m_inpar = 0; m_cnt = 0; m_word = '0;
        sb_q.delete();
    endtask

    task automatic tick(input bit st, input bit ms, input bit sv, input bit sd, input int rdy_force);
        bit rdy, done, pe, eab, eov, cons;
        case (rdy_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (rdy_force >= 0) rdy = (rdy_force != 0);
        Start_In = st; Msb_First_In = ms; Serial_Valid_In = sv; Serial_Data_In = sd;
        Word_Ready_In = rdy;
        @(posedge Clk_In);
        done = 0; pe = 0; eab = 0; eov = 0;
        cons = m_full && rdy;
        if (st) begin
            eab = m_busy;
            m_busy = 1; m_cnt = 0; m_word = '0; m_msb = ms; m_inpar = 0;
        end else if (m_busy && sv) begin
            if (m_inpar) begin
                done = 1;
                pe = ((^m_word) ^ sd) != POD;
            end else begin
                if (m_msb) m_word[DW-1-m_cnt] = sd;
                else       m_word[m_cnt] = sd;
                m_cnt++;
                if (m_cnt == DW) begin
`ifdef USR_RX_PARITY_EN
                    m_inpar = 1;
`else
                    done = 1;
`endif
                end
            end
        end
        if (done) begin
            m_busy = 0; m_cnt = 0; m_inpar = 0;
            if (m_full && !rdy) eov = 1;
            else begin
                sb_q.push_back('{m_word, pe});
                m_full = 1;
            end
        end else if (cons) begin
            m_full = 0;
        end
        #1;
        chk("overrun", 32'(Overrun_Out), 32'(eov));
        chk("abort", 32'(Abort_Out), 32'(eab));
        chk("valid", 32'(Word_Valid_Out), 32'(m_full));
        chk("busy", 32'(Busy_Out), 32'(m_busy));
        chk("bit_count", 32'(Bit_Count_Out), 32'(m_cnt));
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input bit msb, input int nbits,
                             input int gap_pct, input int rdy_last);
        bit b;
        tick(1'b1, msb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        for (int i = 0; i < nbits; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct)
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), -1);
            b = msb ? w[DW-1-i] : w[i];
            tick(1'b0, 1'($urandom_range(0, 1)), 1'b1, b, (i == DW - 1) ? rdy_last : -1);
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] w, input bit msb, input int gap_pct,
                              input bit pflip, input int rdy_last);
`ifdef USR_RX_PARITY_EN
        send_bits(w, msb, DW, gap_pct, -1);
        tick(1'b0, 1'b0, 1'b1, (^w) ^ POD ^ pflip, rdy_last);
`else
        if (pflip) begin end
        send_bits(w, msb, DW, gap_pct, rdy_last);
`endif
    endtask

    always @(negedge Clk_In) begin
        if (Reset_In && Word_Valid_Out && Word_Ready_In) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", Word_Data_Out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("word_data", 32'(Word_Data_Out), 32'(e.w));
                chk("parity_err", 32'(Parity_Error_Out), 32'(e.pe));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_In = 1'b0;
        Start_In = 0; Msb_First_In = 0; Serial_Valid_In = 0; Serial_Data_In = 0; Word_Ready_In = 0;
        rdy_mode = 0;
        model_clear();
        #1;
        chk("rst_valid", 32'(Word_Valid_Out), 0);
        chk("rst_data", 32'(Word_Data_Out), 0);
        chk("rst_busy", 32'(Busy_Out), 0);
        chk("rst_count", 32'(Bit_Count_Out), 0);
        repeat (2) @(posedge Clk_In);
        #1 Reset_In = 1'b1;

        send_frame(16'hA5C3, 1'b1, 0, 1'b0, -1);
        repeat (2) tick(0, 0, 0, 0, -1);

        send_frame(16'h1234, 1'b0, 0, 1'b0, -1);
        send_frame(16'h1234, 1'b0, 40, 1'b0, -1);
        repeat (2) tick(0, 0, 0, 0, -1);

        rdy_mode = 1;
        send_frame(16'h00FF, 1'b1, 0, 1'b0, -1);
        repeat (2) tick(0, 0, 0, 0, -1);
        send_frame(16'hFFFF, 1'b0, 10, 1'b0, -1);
        send_frame(16'h5A5A, 1'b1, 0, 1'b0, 1);
        rdy_mode = 0;
        repeat (2) tick(0, 0, 0, 0, -1);

        send_bits(16'h0F0F, 1'b1, 5, 0, -1);
        send_frame(16'h00FF, 1'b1, 0, 1'b0, -1);
        send_bits(16'hC3C3, 1'b0, DW - 1, 0, -1);
        tick(1'b1, 1'b1, 1'b1, 1'b1, -1);
        send_bits(16'h8001, 1'b1, DW, 0, -1);
        repeat (2) tick(0, 0, 0, 0, -1);

        send_bits(16'hBEEF, 1'b1, 8, 0, -1);
        Reset_In = 1'b0;
        #1;
        chk("midrst_busy", 32'(Busy_Out), 0);
        chk("midrst_count", 32'(Bit_Count_Out), 0);
        chk("midrst_valid", 32'(Word_Valid_Out), 0);
        chk("midrst_data", 32'(Word_Data_Out), 0);
        chk("midrst_flags", 32'({Overrun_Out, Abort_Out, Parity_Error_Out}), 0);
        model_clear();
        @(posedge Clk_In);
        #1 Reset_In = 1'b1;
        send_frame(16'h1234, 1'b1, 0, 1'b0, -1);
        repeat (2) tick(0, 0, 0, 0, -1);

`ifdef USR_RX_PARITY_EN
        send_frame(16'hA5C3, 1'b1, 0, 1'b0, -1);
        send_frame(16'hA5C3, 1'b1, 0, 1'b1, -1);
        repeat (2) tick(0, 0, 0, 0, -1);
`endif

        rdy_mode = 2;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0)
                send_bits(DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, DW - 1), 20, -1);
            send_frame(DW'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 30),
                       1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) tick(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        end

        rdy_mode = 0;
        repeat (3) tick(0, 0, 0, 0, -1);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
